osc_window_counter: RTL

Measures ring-oscillator frequency. It counts synchronized rising edges of the selected oscillator output over a programmable window of `clk` cycles, then averages 2^AVG_LOG2 consecutive windows. The truncated mean is presented on a valid/ready handshake. It sits directly upstream of the hysteresis comparator and the UART send FSM, and supplies their averaged temperature code.

---
 rtl/osc_window_counter.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/osc_window_counter.sv
`timescale 1ns/1ps
// osc_window_counter
// Counts synchronized rising edges of an asynchronous ring-oscillator output
// over back-to-back windows of win_len clk cycles. It averages 2^AVG_LOG2
// windows and presents the floor of the mean on a valid/ready handshake.
module osc_window_counter #(
   parameter int unsigned CNT_W    = 10,
   parameter int unsigned WIN_W    = 16,
   parameter int unsigned AVG_LOG2 = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             osc_in,
   input  logic [WIN_W-1:0] win_len,
   output logic [CNT_W-1:0] sample,
   output logic             sample_valid,
   input  logic             sample_ready,
   output logic             overflow,
   output logic             busy
);

   // The accumulator holds 2^AVG_LOG2 saturated counts, so it can never wrap.
   localparam int unsigned ACC_W = CNT_W + AVG_LOG2;
   localparam int unsigned IDX_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;

   localparam logic [CNT_W-1:0] CntMax  = {CNT_W{1'b1}};
   localparam logic [IDX_W-1:0] IdxLast = IDX_W'((1 << AVG_LOG2) - 1);
   localparam logic [WIN_W-1:0] WinOne  = WIN_W'(1);

   typedef enum logic [1:0] {
      StIdle,
      StMeasure,
      StHold
   } state_e;

   state_e           state_q, state_d;
   logic [2:0]       sync_q, sync_d;
   logic [WIN_W-1:0] win_len_q, win_len_d;
   logic [WIN_W-1:0] win_cnt_q, win_cnt_d;
   logic [CNT_W-1:0] edge_cnt_q, edge_cnt_d;
   logic [ACC_W-1:0] acc_q, acc_d;
   logic [IDX_W-1:0] win_idx_q, win_idx_d;
   logic             ovf_sticky_q, ovf_sticky_d;
   logic [CNT_W-1:0] sample_q, sample_d;
   logic             overflow_q, overflow_d;

   // Combinational helpers: this cycle's edge folded into the running count.
   logic             edge_det;
   logic [CNT_W-1:0] edge_cnt_inc;
   logic             ovf_inc;
   logic [ACC_W-1:0] acc_sum;

   // Synchronizer shift: [0] and [1] resolve metastability, [2] is the
   // history flop for rising-edge detection.
   always_comb begin
      sync_d = {sync_q[1:0], osc_in};
   end

   assign edge_det = sync_q[1] & ~sync_q[2];

   // Per-cycle edge accounting, shared by the mid-window and end-of-window paths.
   always_comb begin
      edge_cnt_inc = edge_cnt_q;
      ovf_inc      = ovf_sticky_q;
      if (edge_det) begin
         if (edge_cnt_q == CntMax) begin
            ovf_inc = 1'b1;
         end else begin
            edge_cnt_inc = edge_cnt_q + 1'b1;
         end
      end
      acc_sum = acc_q + ACC_W'(edge_cnt_inc);
   end

   // Next-state logic for the IDLE / MEASURE / HOLD controller and its datapath.
   always_comb begin
      state_d      = state_q;
      win_len_d    = win_len_q;
      win_cnt_d    = win_cnt_q;
      edge_cnt_d   = edge_cnt_q;
      acc_d        = acc_q;
      win_idx_d    = win_idx_q;
      ovf_sticky_d = ovf_sticky_q;
      sample_d     = sample_q;
      overflow_d   = overflow_q;

      unique case (state_q)
         StIdle: begin
            // A zero-length window would never terminate, so it is refused.
            if (en && (win_len != '0)) begin
               win_len_d    = win_len;
               win_cnt_d    = win_len;
               edge_cnt_d   = '0;
               acc_d        = '0;
               win_idx_d    = '0;
               ovf_sticky_d = 1'b0;
               state_d      = StMeasure;
            end
         end

         StMeasure: begin
            if (!en) begin
               // Abort: partial results are simply reinitialised on the next start.
               state_d = StIdle;
            end else begin
               ovf_sticky_d = ovf_inc;
               if (win_cnt_q == WinOne) begin
                  // Last cycle of a window; the next window starts with no gap.
                  acc_d      = acc_sum;
                  edge_cnt_d = '0;
                  win_cnt_d  = win_len_q;
                  win_idx_d  = win_idx_q + 1'b1;
                  if (win_idx_q == IdxLast) begin
                     sample_d   = CNT_W'(acc_sum >> AVG_LOG2);
                     overflow_d = ovf_inc;
                     state_d    = StHold;
                  end
               end else begin
                  edge_cnt_d = edge_cnt_inc;
                  win_cnt_d  = win_cnt_q - 1'b1;
               end
            end
         end

         StHold: begin
            // Sample stays put until consumed; en and oscillator edges are ignored.
            if (sample_ready) begin
               overflow_d = 1'b0;
               state_d    = StIdle;
            end
         end

         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // State and datapath registers, all cleared asynchronously.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= StIdle;
         sync_q       <= '0;
         win_len_q    <= '0;
         win_cnt_q    <= '0;
         edge_cnt_q   <= '0;
         acc_q        <= '0;
         win_idx_q    <= '0;
         ovf_sticky_q <= 1'b0;
         sample_q     <= '0;
         overflow_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         sync_q       <= sync_d;
         win_len_q    <= win_len_d;
         win_cnt_q    <= win_cnt_d;
         edge_cnt_q   <= edge_cnt_d;
         acc_q        <= acc_d;
         win_idx_q    <= win_idx_d;
         ovf_sticky_q <= ovf_sticky_d;
         sample_q     <= sample_d;
         overflow_q   <= overflow_d;
      end
   end

   assign sample       = sample_q;
   assign overflow     = overflow_q;
   assign sample_valid = (state_q == StHold);
   assign busy         = (state_q != StIdle);

endmodule
